// File: rtl/pixel_fetch.sv
// pixel_fetch: prefetches framebuffer rows into a small FIFO for the VGA generator.
// Optional PIXEL_FETCH_PATTERN_EN adds i_pattern_en for a generated test pattern.
module pixel_fetch #(
  parameter int H_PIXELS    = 32,
  parameter int V_LINES     = 48,
  parameter int LINE_REPEAT = 10,
  parameter int ADDR_W      = 11,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_screen_reset,
  input  logic              i_pixel_x_clock,
  input  logic              i_pixel_y_clock,
`ifdef PIXEL_FETCH_PATTERN_EN
  input  logic              i_pattern_en,
`endif
  output logic [11:0]       o_color,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_valid,
  input  logic [11:0]       i_mem_data,
  output logic              o_underflow
);
  localparam int ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int REP_W = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
  localparam int COL_W = $clog2(H_PIXELS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [COL_W-1:0]  COL_END    = COL_W'(H_PIXELS);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(V_LINES - 1);
  localparam logic [REP_W-1:0]  REP_LAST   = REP_W'(LINE_REPEAT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_PIXELS);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, LINE_DONE} state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row;
  logic [REP_W-1:0]  rep;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] row_base;
  logic [11:0]       fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              busy, discard;
  logic              y_go, x_go, issue, push, pop;
`ifdef PIXEL_FETCH_PATTERN_EN
  logic [3:0]        x_cnt;
`endif

  // Strobe priority: screen reset over y over x; y is ignored before the first frame.
  assign y_go  = i_pixel_y_clock && !i_screen_reset && (state_q != IDLE);
  assign x_go  = i_pixel_x_clock && !i_screen_reset && !i_pixel_y_clock;
  assign issue = (state_q == FETCH) && !busy && (col < COL_END) &&
                 (count < CNT_FULL) && !i_screen_reset && !i_pixel_y_clock;
  assign push  = i_mem_valid && busy && !discard && !i_screen_reset && !y_go;
  assign pop   = x_go && (count != '0);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; any flush restarts fetching for the new line.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (i_screen_reset) state_d = FETCH;
      FETCH: begin
        if (issue)                state_d = WAIT;
        else if (col == COL_END)  state_d = LINE_DONE;
      end
      WAIT:      if (i_mem_valid && busy) state_d = FETCH;
      LINE_DONE: state_d = LINE_DONE;
      default:   state_d = IDLE;
    endcase
    if (state_q != IDLE && (i_screen_reset || i_pixel_y_clock))
      state_d = FETCH;
  end

  // FIFO storage; contents are only meaningful below count.
  always_ff @(posedge i_clk) begin
    if (push) fifo[wr_ptr] <= i_mem_data;
  end

  // Position tracking, read requests, FIFO pointers and colour output.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      row         <= '0;
      rep         <= '0;
      col         <= '0;
      row_base    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      busy        <= 1'b0;
      discard     <= 1'b0;
      o_color     <= '0;
      o_mem_rd    <= 1'b0;
      o_mem_addr  <= '0;
      o_underflow <= 1'b0;
`ifdef PIXEL_FETCH_PATTERN_EN
      x_cnt       <= '0;
`endif
    end else begin
      o_mem_rd <= 1'b0;
      if (i_mem_valid && busy) begin
        busy    <= 1'b0;
        discard <= 1'b0;
      end
      if (i_screen_reset || y_go) begin
        col     <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        o_color <= '0;
`ifdef PIXEL_FETCH_PATTERN_EN
        x_cnt   <= '0;
`endif
        if (busy && !i_mem_valid) discard <= 1'b1;
        if (i_screen_reset) begin
          row         <= '0;
          rep         <= '0;
          row_base    <= '0;
          o_underflow <= 1'b0;
        end else if (rep == REP_LAST) begin
          rep <= '0;
          if (row == ROW_LAST) begin
            row      <= '0;
            row_base <= '0;
          end else begin
            row      <= row + 1'b1;
            row_base <= row_base + ROW_STRIDE;
          end
        end else begin
          rep <= rep + 1'b1;
        end
      end else begin
        if (issue) begin
          o_mem_rd   <= 1'b1;
          o_mem_addr <= row_base + ADDR_W'(col);
          col        <= col + 1'b1;
          busy       <= 1'b1;
        end
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
        if (x_go) begin
          if (pop) begin
            o_color <= fifo[rd_ptr];
          end else begin
            o_color     <= '0;
            o_underflow <= 1'b1;
          end
`ifdef PIXEL_FETCH_PATTERN_EN
          if (i_pattern_en) begin
            o_color     <= {x_cnt, 4'(row), x_cnt ^ 4'(row)};
            o_underflow <= o_underflow;
          end
          x_cnt <= x_cnt + 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// tb_pixel_fetch: directed bench for pixel_fetch with a 2-cycle
// echo memory (data = address) that can be stalled.
module tb_pixel_fetch;
  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_screen_reset = 1'b0;
  logic        i_pixel_x_clock = 1'b0;
  logic        i_pixel_y_clock = 1'b0;
  logic        i_mem_valid = 1'b0;
  logic [11:0] i_mem_data = '0;
`ifdef PIXEL_FETCH_PATTERN_EN
  logic        i_pattern_en = 1'b0;
`endif
  logic [11:0] o_color;
  logic        o_mem_rd;
  logic [10:0] o_mem_addr;
  logic        o_underflow;

  int          errs = 0;
  int          checks = 0;
  int          ycnt = 0;
  logic        mem_stall = 1'b0;
  logic        p1_v = 1'b0;
  logic [10:0] p1_a = '0;
  logic [10:0] reqs [$];

  always #5 clk = ~clk;

  pixel_fetch dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_screen_reset  (i_screen_reset),
    .i_pixel_x_clock (i_pixel_x_clock),
    .i_pixel_y_clock (i_pixel_y_clock),
`ifdef PIXEL_FETCH_PATTERN_EN
    .i_pattern_en    (i_pattern_en),
`endif
    .o_color         (o_color),
    .o_mem_rd        (o_mem_rd),
    .o_mem_addr      (o_mem_addr),
    .i_mem_valid     (i_mem_valid),
    .i_mem_data      (i_mem_data),
    .o_underflow     (o_underflow)
  );

  // Memory: a request seen at one falling edge answers at the next
  // unstalled falling edge, i.e. two rising edges after the request.
  always @(negedge clk) begin
    i_mem_valid = 1'b0;
    if (p1_v && !mem_stall) begin
      i_mem_valid = 1'b1;
      i_mem_data  = {1'b0, p1_a};
      p1_v        = 1'b0;
    end
    if (o_mem_rd) begin
      p1_v = 1'b1;
      p1_a = o_mem_addr;
      reqs.push_back(o_mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xs();
    i_pixel_x_clock = 1'b1;
    tick();
    i_pixel_x_clock = 1'b0;
  endtask

  task automatic ys();
    i_pixel_y_clock = 1'b1;
    tick();
    i_pixel_y_clock = 1'b0;
    ycnt++;
  endtask

  task automatic sr();
    i_screen_reset = 1'b1;
    tick();
    i_screen_reset = 1'b0;
    ycnt = 0;
  endtask

  task automatic first_req(input string tag, input int exp);
    if (reqs.size() == 0) check({tag, "_seen"}, 0, 1);
    else                  check(tag, 32'(reqs[0]), exp);
  endtask

  // Prefetch, then consume one full row slowly enough never to starve.
  task automatic run_line(input int row);
    tick(30);
    first_req("line_first_req", row * 32);
    for (int i = 0; i < 32; i++) begin
      xs();
      check("line_color", 32'(o_color), row * 32 + i);
      tick(3);
    end
  endtask

  initial begin
    // Reset state and idle behaviour
    tick(2);
    check("rst_color", 32'(o_color), 0);
    check("rst_rd", 32'(o_mem_rd), 0);
    check("rst_addr", 32'(o_mem_addr), 0);
    check("rst_uf", 32'(o_underflow), 0);
    i_reset = 1'b0;
    tick(5);
    check("idle_no_reqs", reqs.size(), 0);

    // Frame start: fill stalls at FIFO depth, then row 0 in order
    sr();
    tick(30);
    check("fill_reqs", reqs.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < reqs.size()) check("fill_addr", 32'(reqs[i]), i);
    end
    for (int i = 0; i < 8; i++) begin
      xs();
      check("burst_color", 32'(o_color), i);
    end
    tick(3);
    for (int i = 8; i < 32; i++) begin
      xs();
      check("line0_color", 32'(o_color), i);
      tick(3);
    end
    check("line0_uf", 32'(o_underflow), 0);
    ys();
    check("y_color", 32'(o_color), 0);

    // Row repetition: ten lines of row 0, then row 1 at address 32
    for (int l = 1; l <= 10; l++) begin
      reqs.delete();
      run_line(l / 10);
      ys();
      check("y_color", 32'(o_color), 0);
    end
    check("lines_uf", 32'(o_underflow), 0);

    // Fast forward to row 47, then wrap to row 0
    while (ycnt < 479) begin
      tick(4);
      ys();
    end
    reqs.delete();
    tick(10);
    first_req("row47_req", 47 * 32);
    ys();
    reqs.delete();
    tick(10);
    first_req("wrap_req", 0);

    // Underflow: stalled memory, pop an empty FIFO
    mem_stall = 1'b1;
    ys();
    tick(10);
    check("pre_uf", 32'(o_underflow), 0);
    xs();
    check("uf_color", 32'(o_color), 0);
    check("uf_set", 32'(o_underflow), 1);
    ys();
    check("uf_held_y", 32'(o_underflow), 1);
    check("uf_y_color", 32'(o_color), 0);
    reqs.delete();
    sr();
    check("uf_cleared", 32'(o_underflow), 0);

    // y strobe with a read outstanding; data returns one cycle later
    mem_stall = 1'b0;
    tick(30);
    xs();
    check("t5_color0", 32'(o_color), 0);
    xs();
    check("t5_color1", 32'(o_color), 1);
    mem_stall = 1'b1;
    tick(5);
    if (reqs.size() == 0) check("t5_pending_seen", 0, 1);
    else check("t5_pending", 32'(reqs[reqs.size() - 1]), 8);
    i_pixel_y_clock = 1'b1;
    tick();
    i_pixel_y_clock = 1'b0;
    ycnt++;
    mem_stall = 1'b0;
    reqs.delete();
    check("t5_y_color", 32'(o_color), 0);
    tick(15);
    first_req("t5_req", 0);
    xs();
    check("t5_head", 32'(o_color), 0);
    xs();
    check("t5_next", 32'(o_color), 1);

    // Reset mid-line with a read outstanding
    mem_stall = 1'b1;
    tick(5);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("mid_rst_color", 32'(o_color), 0);
    check("mid_rst_rd", 32'(o_mem_rd), 0);
    check("mid_rst_addr", 32'(o_mem_addr), 0);
    check("mid_rst_uf", 32'(o_underflow), 0);
    reqs.delete();
    mem_stall = 1'b0;
    tick(20);
    check("mid_rst_no_reqs", reqs.size(), 0);

    // Restart, full row 0, then one strobe beyond the row width
    sr();
    run_line(0);
    check("full_line_uf", 32'(o_underflow), 0);
    xs();
    check("extra_x_color", 32'(o_color), 0);
    check("extra_x_uf", 32'(o_underflow), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
